// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath shifter.
// Mode codes, direction codes and the per-bit select used by the cells.
package pong_pkg;

    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_SHIFT  = 3'd1;
    localparam logic [2:0] MODE_ROTATE = 3'd2;
    localparam logic [2:0] MODE_LOAD   = 3'd3;
    localparam logic [2:0] MODE_BOUNCE = 3'd4;
    localparam logic [2:0] MODE_CLEAR  = 3'd5;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_LOWER = 3'd1,
        SEL_UPPER = 3'd2,
        SEL_LOAD  = 3'd3,
        SEL_CLEAR = 3'd4
    } cell_sel_e;

endpackage

// File: rtl/shift_register_n_cell.sv
// One bit of the shifter: next-value mux feeding a
// synchronous-reset flip-flop.
module shift_reg_cell
    import pong_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  cell_sel_e i_sel,
    input  logic      i_lower,
    input  logic      i_upper,
    input  logic      i_load,
    input  logic      i_rst_val,
    output logic      o_q
);

    logic r_q;
    logic w_next;

    // Pick the next bit value from the shared select
    always_comb begin
        w_next = r_q;
        case (i_sel)
            SEL_LOWER: w_next = i_lower;
            SEL_UPPER: w_next = i_upper;
            SEL_LOAD:  w_next = i_load;
            SEL_CLEAR: w_next = 1'b0;
            default:   w_next = r_q;
        endcase
    end

    // Bit storage with synchronous reset to its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= i_rst_val;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_register_n.sv
// N-bit bidirectional shifter with rotate, load, clear and
// an autonomous bounce walk that reverses at either wall.
module shift_register_n
    import pong_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [2:0]       mode,
    input  logic             side,
    input  logic             data,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] dataout,
    output logic             serial_out,
    output logic             dir,
    output logic             edge_hit
);

    logic             r_dir;
    logic             r_edge_hit;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_lower;
    logic [WIDTH-1:0] w_upper;
    cell_sel_e        w_sel;
    logic             w_fill_lo;
    logic             w_fill_hi;
    logic             w_dir_nxt;
    logic             w_hit_nxt;
    logic             w_msb;
    logic             w_lsb;

    assign w_msb = w_q[WIDTH-1];
    assign w_lsb = w_q[0];

    // Decode mode into a shared cell select, fills and bounce state
    always_comb begin
        w_sel     = SEL_HOLD;
        w_fill_lo = data;
        w_fill_hi = data;
        w_dir_nxt = r_dir;
        w_hit_nxt = 1'b0;
        if (step) begin
            case (mode)
                MODE_SHIFT: begin
                    w_sel = side ? SEL_LOWER : SEL_UPPER;
                end
                MODE_ROTATE: begin
                    w_fill_lo = w_msb;
                    w_fill_hi = w_lsb;
                    w_sel     = side ? SEL_LOWER : SEL_UPPER;
                end
                MODE_LOAD: begin
                    w_sel     = SEL_LOAD;
                    w_dir_nxt = side;
                end
                MODE_BOUNCE: begin
                    w_fill_lo = 1'b0;
                    w_fill_hi = 1'b0;
                    if (w_msb && w_lsb) begin
                        w_hit_nxt = 1'b1;
                    end else if (w_q == '0) begin
                        w_sel = SEL_HOLD;
                    end else if (r_dir == DIR_UP) begin
                        if (w_msb) begin
                            w_dir_nxt = DIR_DOWN;
                            w_sel     = SEL_UPPER;
                            w_hit_nxt = 1'b1;
                        end else begin
                            w_sel = SEL_LOWER;
                        end
                    end else begin
                        if (w_lsb) begin
                            w_dir_nxt = DIR_UP;
                            w_sel     = SEL_LOWER;
                            w_hit_nxt = 1'b1;
                        end else begin
                            w_sel = SEL_UPPER;
                        end
                    end
                end
                MODE_CLEAR: begin
                    w_sel = SEL_CLEAR;
                end
                default: begin
                    w_sel = SEL_HOLD;
                end
            endcase
        end
    end

    // Neighbour bits seen by each cell, with the end fills spliced in
    assign w_lower = {w_q[WIDTH-2:0], w_fill_lo};
    assign w_upper = {w_fill_hi, w_q[WIDTH-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            shift_reg_cell u_cell (
                .clk       (clk),
                .rst       (rst),
                .i_sel     (w_sel),
                .i_lower   (w_lower[gi]),
                .i_upper   (w_upper[gi]),
                .i_load    (load_value[gi]),
                .i_rst_val (RESET_VALUE[gi]),
                .o_q       (w_q[gi])
            );
        end
    endgenerate

    // Bounce direction and wall-hit pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir      <= DIR_UP;
            r_edge_hit <= 1'b0;
        end else begin
            r_dir      <= w_dir_nxt;
            r_edge_hit <= w_hit_nxt;
        end
    end

    assign dataout    = w_q;
    assign serial_out = side ? w_msb : w_lsb;
    assign dir        = r_dir;
    assign edge_hit   = r_edge_hit;

endmodule

// File: tb/tb_shift_register_n.sv
// Directed bench for shift_register_n (WIDTH=5, RESET_VALUE=00101).
// Each scenario task drives vectors and checks its own results.
module tb_shift_register_n;

    localparam int         W  = 5;
    localparam logic [4:0] RV = 5'b00101;

    localparam logic [2:0] M_HOLD   = 3'd0;
    localparam logic [2:0] M_SHIFT  = 3'd1;
    localparam logic [2:0] M_ROTATE = 3'd2;
    localparam logic [2:0] M_LOAD   = 3'd3;
    localparam logic [2:0] M_BOUNCE = 3'd4;
    localparam logic [2:0] M_CLEAR  = 3'd5;

    logic         clk = 1'b0;
    logic         rst;
    logic         step;
    logic [2:0]   mode;
    logic         side;
    logic         data;
    logic [W-1:0] load_value;
    logic [W-1:0] dataout;
    logic         serial_out;
    logic         dir;
    logic         edge_hit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_register_n #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .mode       (mode),
        .side       (side),
        .data       (data),
        .load_value (load_value),
        .dataout    (dataout),
        .serial_out (serial_out),
        .dir        (dir),
        .edge_hit   (edge_hit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic s);
        step       = 1'b1;
        mode       = M_LOAD;
        side       = s;
        load_value = v;
        tick();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        step = 1'b1;
        mode = M_BOUNCE;
        tick();
        rst = 1'b0;
        step = 1'b0;
        n_checks++;
        if (dataout !== RV) begin
            n_fail++;
            $display("FAIL reset_data got %b exp %b", dataout, RV);
        end
        n_checks++;
        if (dir !== 1'b1 || edge_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got dir=%b hit=%b exp dir=1 hit=0",
                     dir, edge_hit);
        end
    endtask

    task automatic test_shift();
        logic [4:0] exp_d [4];
        logic       din   [4];
        logic       sd    [4];
        logic       exp_so[4];
        exp_d  = '{5'b00001, 5'b00010, 5'b00101, 5'b10010};
        din    = '{1'b1, 1'b0, 1'b1, 1'b1};
        sd     = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_so = '{1'b0, 1'b0, 1'b0, 1'b1};
        step = 1'b1;
        mode = M_CLEAR;
        tick();
        n_checks++;
        if (dataout !== 5'b00000) begin
            n_fail++;
            $display("FAIL clear got %b exp 00000", dataout);
        end
        mode = M_SHIFT;
        for (int i = 0; i < 4; i++) begin
            data = din[i];
            side = sd[i];
            #1;
            n_checks++;
            if (serial_out !== exp_so[i]) begin
                n_fail++;
                $display("FAIL shift_serial_out[%0d] got %b exp %b",
                         i, serial_out, exp_so[i]);
            end
            tick();
            n_checks++;
            if (dataout !== exp_d[i] || edge_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL shift[%0d] got %b hit=%b exp %b hit=0",
                         i, dataout, edge_hit, exp_d[i]);
            end
        end
    endtask

    task automatic test_rotate_hold();
        data = 1'b0;
        do_load(5'b10001, 1'b1);
        n_checks++;
        if (dataout !== 5'b10001 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL load got %b dir=%b exp 10001 dir=1", dataout, dir);
        end
        mode = M_ROTATE;
        side = 1'b1;
        tick();
        n_checks++;
        if (dataout !== 5'b00011) begin
            n_fail++;
            $display("FAIL rotate_up got %b exp 00011", dataout);
        end
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dataout !== 5'b00011 || edge_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_gate[%0d] got %b hit=%b exp 00011 hit=0",
                         i, dataout, edge_hit);
            end
        end
        step = 1'b1;
        side = 1'b0;
        tick();
        n_checks++;
        if (dataout !== 5'b10001) begin
            n_fail++;
            $display("FAIL rotate_down got %b exp 10001", dataout);
        end
    endtask

    task automatic test_bounce_walk();
        logic [4:0] exp_d [9];
        logic       exp_h [9];
        logic       exp_r [9];
        exp_d = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                  5'b00100, 5'b00010, 5'b00001, 5'b00010};
        exp_h = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        exp_r = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        do_load(5'b00001, 1'b1);
        mode = M_BOUNCE;
        side = 1'b0;
        data = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (dataout !== exp_d[i] || edge_hit !== exp_h[i]
                || dir !== exp_r[i]) begin
                n_fail++;
                $display("FAIL bounce[%0d] got %b hit=%b dir=%b exp %b hit=%b dir=%b",
                         i, dataout, edge_hit, dir, exp_d[i], exp_h[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_bounce_corners();
        do_load(5'b10001, 1'b1);
        mode = M_BOUNCE;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            n_checks++;
            if (dataout !== 5'b10001 || edge_hit !== 1'b1 || dir !== 1'b1) begin
                n_fail++;
                $display("FAIL span[%0d] got %b hit=%b dir=%b exp 10001 hit=1 dir=1",
                         i, dataout, edge_hit, dir);
            end
            step = 1'b0;
            tick();
            n_checks++;
            if (dataout !== 5'b10001 || edge_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL span_idle[%0d] got %b hit=%b exp 10001 hit=0",
                         i, dataout, edge_hit);
            end
        end
        do_load(5'b00000, 1'b1);
        mode = M_BOUNCE;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (dataout !== 5'b00000 || edge_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL empty[%0d] got %b hit=%b exp 00000 hit=0",
                         i, dataout, edge_hit);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_load(5'b00001, 1'b1);
        mode = M_BOUNCE;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (dataout !== 5'b01000 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset got %b dir=%b exp 01000 dir=0", dataout, dir);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (dataout !== RV || dir !== 1'b1 || edge_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got %b dir=%b hit=%b exp %b dir=1 hit=0",
                     dataout, dir, edge_hit, RV);
        end
        mode = 3'd7;
        side = 1'b0;
        data = 1'b1;
        tick();
        n_checks++;
        if (dataout !== RV || dir !== 1'b1 || edge_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved7 got %b dir=%b exp %b dir=1", dataout, dir, RV);
        end
        mode = M_HOLD;
        tick();
        n_checks++;
        if (dataout !== RV) begin
            n_fail++;
            $display("FAIL hold_mode got %b exp %b", dataout, RV);
        end
    endtask

    task automatic test_clear_keeps_dir();
        do_load(5'b10110, 1'b0);
        n_checks++;
        if (dataout !== 5'b10110 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL load_dir got %b dir=%b exp 10110 dir=0", dataout, dir);
        end
        mode = M_CLEAR;
        side = 1'b1;
        tick();
        n_checks++;
        if (dataout !== 5'b00000 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_dir got %b dir=%b exp 00000 dir=0", dataout, dir);
        end
    endtask

    initial begin
        rst        = 1'b0;
        step       = 1'b0;
        mode       = M_HOLD;
        side       = 1'b0;
        data       = 1'b0;
        load_value = '0;
        test_reset();
        test_shift();
        test_rotate_hold();
        test_bounce_walk();
        test_bounce_corners();
        test_reset_mid();
        test_clear_keeps_dir();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_register_n.md
Name: shift_register_n

Overview:
- Parametrised N-bit bidirectional shift register; next generation of the 5-bit LED/paddle shifter used in the pong datapath.
- Adds step enable, parallel load, rotate and clear modes.
- Adds an autonomous "bounce" mode: a one-hot ball pattern walks across the row and reverses at either end, flagging each wall hit.
- Sits between the game-tick generator and the LED row / collision logic.

Parameters:
- WIDTH, 5, number of register bits; legal range 2..32.
- RESET_VALUE, 0, WIDTH-bit value loaded into dataout on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- step  input  1  advance enable; the register changes only in cycles where step=1.
- mode  input  3  operation select; encoding in Behaviour.
- side  input  1  direction: 1 = toward MSB (bit i to i+1), 0 = toward LSB (bit i+1 to i).
- data  input  1  serial input; enters bit 0 when side=1, bit WIDTH-1 when side=0.
- load_value  input  WIDTH  parallel load value.
- dataout  output  WIDTH  register contents.
- serial_out  output  1  combinational; bit that the next shift would drop: side ? dataout[WIDTH-1] : dataout[0].
- dir  output  1  registered bounce direction (1 = toward MSB).
- edge_hit  output  1  registered one-cycle pulse; asserted when a bounce reversal occurs.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. On rst=1 at a clock edge: dataout=RESET_VALUE, dir=1, edge_hit=0. Reset has priority over step and mode, including mid-bounce.
- step=0: dataout and dir hold; edge_hit=0 next cycle.
- Latency: every update is visible one clock after the step edge. edge_hit is valid in the same cycle as the updated dataout.
- Mode encoding (evaluated only when step=1):
  - 0 HOLD: no change.
  - 1 SHIFT: shift by side; vacated end filled with data.
  - 2 ROTATE: shift by side; vacated end filled with the bit shifted out; data is ignored.
  - 3 LOAD: dataout=load_value; dir=side.
  - 4 BOUNCE: autonomous walk, defined below; data and side are ignored.
  - 5 CLEAR: dataout=0; dir unchanged.
  - 6, 7 reserved: behave as HOLD.
- BOUNCE, with msb=dataout[WIDTH-1] and lsb=dataout[0]:
  - dir=1, msb=0: shift toward MSB, fill 0.
  - dir=1, msb=1, lsb=0: dir becomes 0; shift toward LSB in the same step (no dwell at the wall); edge_hit=1.
  - dir=0, lsb=0: shift toward LSB, fill 0.
  - dir=0, lsb=1, msb=0: dir becomes 1; shift toward MSB in the same step; edge_hit=1.
  - msb=1 and lsb=1: no shift, dir unchanged, edge_hit=1 (pattern spans the row).
  - dataout=0: stays 0, no edge_hit.
- Patterns that are not one-hot shift as a whole; reversal is decided only from the end bits.
- Mode changes take effect on the next step with no flush. dir persists across modes other than LOAD.
- edge_hit is 0 in every mode except BOUNCE.

Decomposition:
- Shared package pong_pkg:
  - mode localparams MODE_HOLD=0, MODE_SHIFT=1, MODE_ROTATE=2, MODE_LOAD=3, MODE_BOUNCE=4, MODE_CLEAR=5;
  - DIR_UP=1, DIR_DOWN=0.
- One natural sub-module, shift_reg_cell: a per-bit next-value mux (hold / from lower / from upper / load / clear) feeding a synchronous-reset D flip-flop, instantiated WIDTH times by a generate loop.
- Bounce direction and edge logic stay in the top module.

Test Plan:
- Reset: RESET_VALUE=5'b00101, rst=1 for 1 cycle with step=1 and mode=BOUNCE -> dataout=00101, dir=1, edge_hit=0.
- SHIFT: dataout=00000, side=1, data sequence 1,0,1 with step=1 -> 00001, 00010, 00101. Then side=0, data=1 -> 10010. serial_out equals the pre-shift dropped bit each cycle.
- ROTATE and HOLD gating: load 10001 (side=1), ROTATE side=1 -> 00011. Hold step=0 for 3 cycles -> unchanged. ROTATE side=0 -> 10001.
- BOUNCE walk: load 00001 with side=1, then 8 steps -> 00010, 00100, 01000, 10000, 01000 (edge_hit=1, dir=0), 00100, 00010, 00001. A 9th step gives 00010 with edge_hit=1 and dir=1.
- Bounce corner cases: load 10001 then BOUNCE -> 10001 held, edge_hit=1 every step. Load 00000 -> stays 00000, edge_hit=0. Idle cycles with step=0 interleaved -> no advance, edge_hit=0.
- Reset mid-operation: during BOUNCE at 01000 with dir=0, assert rst -> next cycle RESET_VALUE, dir=1. Reserved mode=7 with step=1 -> no change.
